i2s_sample_sched: RTL
=====================

// Module: i2s_sample_sched
// PURPOSE
//  Frame-rate sequencer and source arbiter feeding the I2S transmitter's left_chan/right_chan.
//  Pulls stereo samples from two valid/ready requesters (src0 = Paula mixer, src1 = aux/CD),
//  selects or mixes them per cfg_mode, and buffers them in a 4-deep FIFO.
//  Presents one new stereo pair per audio frame, timed to the transmitter's sclk/lrclk cadence.
// PARAMETERS
//  CLK_DIV    50  clk cycles per sclk minus 1; sclk period = CLK_DIV+1 clk. Must equal the transmitter's value.
//  AUDIO_DW   16  sample width (signed two's complement)
//  FIFO_DEPTH 4   stereo entries; power of two, >=2
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         async active-low reset
//  cfg_en         in   1         1 = run frame timer and fetching; 0 = idle, FIFO flushed
//  cfg_prescaler  in   AUDIO_DW  sclk cycles per channel; same value as the transmitter's prescaler
//  cfg_mode       in   2         00 src0, 01 src1, 10 saturating mix src0+src1, 11 mute
//  src0_valid     in   1         src0 sample pair available
//  src0_ready     out  1         src0 pair consumed this cycle
//  src0_left      in   AUDIO_DW
//  src0_right     in   AUDIO_DW
//  src1_valid/src1_ready/src1_left/src1_right   same as src0
//  out_left       out  AUDIO_DW  to transmitter left_chan
//  out_right      out  AUDIO_DW  to transmitter right_chan
//  frame_tick     out  1         1-clk pulse at each frame boundary
//  fifo_level     out  3         entries held, 0..FIFO_DEPTH
//  underrun_cnt   out  8         saturating count of frames with empty FIFO
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, frame counter 0, FIFO empty, src*_ready 0.
//  Frame timer: counts 0..FRAME-1 with FRAME = (CLK_DIV+1)*2*cfg_prescaler clk cycles.
//   - frame_tick=1 in the cycle the counter equals FRAME-1; the counter then wraps to 0.
//   - cfg_prescaler==0 is treated as 1.
//   - A cfg_prescaler change takes effect at the next wrap.
//  On frame_tick:
//   - FIFO non-empty: pop; out_left/out_right take the head entry one clk later (latency 1).
//   - FIFO empty: outputs hold the previous pair; underrun_cnt += 1, saturating at 255.
//  Fill FSM (states IDLE, FILL, HOLD), evaluated every clk:
//   - IDLE: cfg_en=0. FIFO flushed, frame counter 0, readies 0. cfg_en=1 -> FILL.
//   - FILL: while fifo_level < FIFO_DEPTH, push one pair per clk according to cfg_mode:
//       00: src0_ready = src0_valid; push the src0 pair. src1_ready = 0.
//       01: mirror of 00 for src1.
//       10: push only when both valids=1; both readies=1 in that cycle.
//           Each channel = clamp(sext(a)+sext(b)) into [-2^(DW-1), 2^(DW-1)-1].
//       11: push 0/0 without consulting sources; both readies=1 (sources drained, never stall).
//   - FIFO full -> HOLD; readies 0.
//   - HOLD: a pop frees a slot -> FILL on the next clk.
//   - cfg_en falling from any state -> IDLE next clk. Pending partial handshakes are dropped;
//     no ready is asserted in that cycle.
//  src*_ready is combinational from valid, mode, fullness and state. No ready is asserted
//   without a push in the same cycle.
//  Simultaneous push and pop in one clk: fifo_level is unchanged; data order is preserved.
//  Pop from a full FIFO with a same-cycle push: allowed (the slot is freed first).
//  cfg_mode change: takes effect on the next push. Entries already in the FIFO are not re-mixed.
//  Reset mid-frame: everything returns to reset values immediately; no tick is emitted.
// STRUCTURE
//  Shared package audio_pkg:
//   - mode encodings MODE_SRC0/MODE_SRC1/MODE_MIX/MODE_MUTE
//   - FSM state constants
//   - sat_add function (AUDIO_DW-generic)
//  Sub-module sample_fifo:
//   - synchronous FIFO, width 2*AUDIO_DW, depth FIFO_DEPTH, async active-low reset
//   - ports push/pop/full/empty/level
//  Frame timer, arbiter/mixer and FSM live in i2s_sample_sched.
// TESTING
//  1. CLK_DIV=3, prescaler=16, mode 00, src0 streams 1,2,3...:
//     frame_tick every 128 clk; out_left = 1,2,3... in order; underrun_cnt=0.
//  2. Mode 10: src0 = 0x7000/0x8100, src1 = 0x2000/0x9000 -> out_left=0x7FFF, out_right=0x8000.
//     src0 = 0x0010, src1 = 0xFFF0 -> 0x0000.
//  3. Both sources idle, cfg_en=1, 300 frames -> outputs stay 0, underrun_cnt saturates at 255.
//  4. Fill to 4, hold src0_valid=1 -> src0_ready=0 until the next tick.
//     On the tick cycle: pop plus push in the same clk, fifo_level stays 4.
//  5. Mode 11 with src0/src1 valid -> both readies 1 until the FIFO is full; outputs 0.
//     Switch to mode 00 -> the 4 buffered zero pairs play first, then src0 data.
//  6. rst_n low mid-frame, then cfg_en toggled low for 1 clk -> outputs 0, FIFO empty,
//     first tick exactly FRAME clk after rst_n release / re-enable.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: source-select modes, fill FSM states, saturating add.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package audio_pkg;

   typedef enum logic [1:0] {
      MODE_SRC0 = 2'b00,
      MODE_SRC1 = 2'b01,
      MODE_MIX  = 2'b10,
      MODE_MUTE = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FILL = 2'b01,
      ST_HOLD = 2'b10
   } fill_state_t;

   // Signed add clamped to the range of a dw-bit two's complement value.
   // Operands arrive sign-extended to 32 bits; the caller truncates the result
   // back to dw bits. Valid for dw <= 31, so the 32-bit sum cannot overflow.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int                 dw);
      logic signed [31:0] sum;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      sum = a + b;
      hi  = (32'sd1 <<< (dw - 1)) - 32'sd1;
      lo  = -hi - 32'sd1;
      if (sum > hi)      return hi;
      else if (sum < lo) return lo;
      return sum;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with synchronous flush; head entry is readable combinationally.
// Latency: a pushed entry is visible at the head one clk after the push.
// Backpressure: push ignored when full unless popped in the same clk; pop ignored when empty.
// Ports: clk, rst_n (async active-low), flush, push/push_dat, pop/head_dat, full, empty, level.
module sample_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign do_pop   = pop && !empty;
   // A pop frees the slot first, so a full FIFO still takes a same-cycle push.
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

endmodule

// File: rtl/i2s_sample_sched.sv
// Frame sequencer and source arbiter/mixer feeding the I2S transmitter sample registers.
// Latency: out_left/out_right take the FIFO head one clk after frame_tick.
// Backpressure: src*_ready only while a FIFO slot is free (or freed by the same-clk pop).
// Ports: clk, rst_n, cfg_en/cfg_prescaler/cfg_mode, src0_*/src1_* valid-ready pairs,
//        out_left/out_right, frame_tick, fifo_level, underrun_cnt.
module i2s_sample_sched
   import audio_pkg::*;
#(
   parameter int CLK_DIV    = 50,
   parameter int AUDIO_DW   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_en,
   input  logic [AUDIO_DW-1:0] cfg_prescaler,
   input  logic [1:0]          cfg_mode,
   input  logic                src0_valid,
   output logic                src0_ready,
   input  logic [AUDIO_DW-1:0] src0_left,
   input  logic [AUDIO_DW-1:0] src0_right,
   input  logic                src1_valid,
   output logic                src1_ready,
   input  logic [AUDIO_DW-1:0] src1_left,
   input  logic [AUDIO_DW-1:0] src1_right,
   output logic [AUDIO_DW-1:0] out_left,
   output logic [AUDIO_DW-1:0] out_right,
   output logic                frame_tick,
   output logic [2:0]          fifo_level,
   output logic [7:0]          underrun_cnt
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [AUDIO_DW-1:0] left;
      logic [AUDIO_DW-1:0] right;
   } pair_t;

   fill_state_t         state_q, state_d;
   logic [31:0]         frame_cnt_q;
   logic [31:0]         frame_len;
   logic [AUDIO_DW-1:0] presc_q;
   logic [AUDIO_DW-1:0] presc_eff;
   logic                push_ok;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic [LVL_W-1:0]    lvl;
   pair_t               push_pair;
   pair_t               head_pair;
   logic [AUDIO_DW-1:0] mix_l;
   logic [AUDIO_DW-1:0] mix_r;

   // ---------------- frame timer ----------------
   // The prescaler is sampled in the first cycle of every frame (counter at 0)
   // and held for the rest of it, so a mid-frame change lands at the next wrap.
   always_comb begin
      presc_eff = presc_q;
      if (frame_cnt_q == '0)
         presc_eff = (cfg_prescaler == '0) ? AUDIO_DW'(1) : cfg_prescaler;
   end

   assign frame_len  = 32'((CLK_DIV + 1) * 2) * 32'(presc_eff);
   assign frame_tick = cfg_en && (frame_cnt_q == frame_len - 32'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         presc_q     <= AUDIO_DW'(1);
      end else begin
         presc_q <= presc_eff;
         if (!cfg_en || frame_tick) frame_cnt_q <= '0;
         else                       frame_cnt_q <= frame_cnt_q + 32'd1;
      end
   end

   // ---------------- arbiter / mixer ----------------
   assign mix_l = AUDIO_DW'(sat_add(32'($signed(src0_left)),  32'($signed(src1_left)),  AUDIO_DW));
   assign mix_r = AUDIO_DW'(sat_add(32'($signed(src0_right)), 32'($signed(src1_right)), AUDIO_DW));

   assign pop     = frame_tick && !empty;
   assign push_ok = cfg_en && (state_q != ST_IDLE) && (!full || pop);

   always_comb begin
      push       = 1'b0;
      src0_ready = 1'b0;
      src1_ready = 1'b0;
      push_pair  = '0;
      case (mode_t'(cfg_mode))
         MODE_SRC0: begin
            push       = push_ok && src0_valid;
            src0_ready = push;
            push_pair  = '{left: src0_left, right: src0_right};
         end
         MODE_SRC1: begin
            push       = push_ok && src1_valid;
            src1_ready = push;
            push_pair  = '{left: src1_left, right: src1_right};
         end
         MODE_MIX: begin
            push       = push_ok && src0_valid && src1_valid;
            src0_ready = push;
            src1_ready = push;
            push_pair  = '{left: mix_l, right: mix_r};
         end
         MODE_MUTE: begin
            // Sources are drained unconditionally so they never stall while muted.
            push       = push_ok;
            src0_ready = push;
            src1_ready = push;
         end
         default: ;
      endcase
   end

   // ---------------- fill FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cfg_en) state_d = ST_FILL;
         ST_FILL: begin
            if (!cfg_en)           state_d = ST_IDLE;
            else if (full && !pop) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!cfg_en)  state_d = ST_IDLE;
            else if (pop) state_d = ST_FILL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   sample_fifo #(
      .WIDTH (2 * AUDIO_DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (!cfg_en),
      .push     (push),
      .push_dat (push_pair),
      .pop      (pop),
      .head_dat (head_pair),
      .full     (full),
      .empty    (empty),
      .level    (lvl)
   );

   assign fifo_level = 3'(lvl);

   // ---------------- output registers ----------------
   // An empty FIFO at a frame boundary leaves the previous pair on the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_left     <= '0;
         out_right    <= '0;
         underrun_cnt <= '0;
      end else if (frame_tick) begin
         if (!empty) begin
            out_left  <= head_pair.left;
            out_right <= head_pair.right;
         end else if (underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
         end
      end
   end

endmodule
